// File: rtl/timing_setter.sv
// timing_setter: time-setting front end that debounces six buttons and drives BCD presets with PE to the timer.
// Ports: CP clock, CR sync active-high reset; H_/M_/S_ UP/DOWN raw buttons; Q_H/Q_M/Q_S current BCD time;
//        D_H/D_M/D_S BCD presets; PE preset-load enable (level, high in SET); SET_MODE high in SET.
module timing_setter #(
    parameter int DEBOUNCE_CYCLES = 200,
    parameter int REPEAT_DELAY    = 5000,
    parameter int REPEAT_PERIOD   = 2000,
    parameter int TIMEOUT_CYCLES  = 50000
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       H_UP,
    input  logic       H_DOWN,
    input  logic       M_UP,
    input  logic       M_DOWN,
    input  logic       S_UP,
    input  logic       S_DOWN,
    input  logic [7:0] Q_H,
    input  logic [7:0] Q_M,
    input  logic [7:0] Q_S,
    output logic [7:0] D_H,
    output logic [7:0] D_M,
    output logic [7:0] D_S,
    output logic       PE,
    output logic       SET_MODE
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic {IDLE, SET} state_t;
    state_t state;
    logic [5:0] raw, s1, s2, deb, deb_d, armed, fire, step, pend, ev;
    logic [DW-1:0] dcnt [6];
    logic [RW-1:0] rcnt [6];
    logic [TW-1:0] tmo;
    assign raw = {S_DOWN, S_UP, M_DOWN, M_UP, H_DOWN, H_UP};
    function automatic logic [7:0] fix(input logic [7:0] v, input logic [7:0] mx);
        return (v[3:0] <= 4'd9 && v <= mx) ? v : 8'h00;
    endfunction
    function automatic logic [7:0] adj(input logic [7:0] v, input logic up, input logic dn, input logic [7:0] mx);
        logic [7:0] inc, dec;
        inc = v == mx ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
        dec = v == 8'h00 ? mx : v[3:0] == 4'd0 ? {v[7:4] - 4'd1, 4'd9} : v - 8'd1;
        return up == dn ? v : up ? inc : dec;
    endfunction
    // armed gates steps so a button held through reset must be released before it counts again
    always_comb begin
        for (int i = 0; i < 6; i++) fire[i] = deb[i] && rcnt[i] == RW'(REPEAT_DELAY);
        step = armed & ((deb & ~deb_d) | fire);
        ev = step | pend;
    end
    // sync stages reset to "pressed" so a button must be seen low after reset before arming
    always_ff @(posedge CP) begin
        if (CR) begin
            s1 <= '1;
            s2 <= '1;
            deb <= '0;
            deb_d <= '0;
            armed <= '0;
            for (int i = 0; i < 6; i++) begin
                dcnt[i] <= '0;
                rcnt[i] <= '0;
            end
        end else begin
            s1 <= raw;
            s2 <= s1;
            deb_d <= deb;
            for (int i = 0; i < 6; i++) begin
                armed[i] <= armed[i] | (~deb[i] & ~s2[i]);
                dcnt[i] <= (s2[i] != deb[i] && dcnt[i] != DW'(DEBOUNCE_CYCLES - 1)) ? dcnt[i] + 1'b1 : '0;
                if (s2[i] != deb[i] && dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) deb[i] <= s2[i];
                // reload so the next repeat lands exactly REPEAT_PERIOD cycles later
                rcnt[i] <= !deb[i] ? '0 : fire[i] ? RW'(REPEAT_DELAY - REPEAT_PERIOD + 1) : rcnt[i] + 1'b1;
            end
        end
    end
    // the step that triggers entry is parked in pend and applied one cycle after the capture
    always_ff @(posedge CP) begin
        if (CR) begin
            state <= IDLE;
            PE <= 1'b0;
            SET_MODE <= 1'b0;
            D_H <= 8'h00;
            D_M <= 8'h00;
            D_S <= 8'h00;
            pend <= '0;
            tmo <= '0;
        end else if (state == IDLE) begin
            if (|step) begin
                state <= SET;
                PE <= 1'b1;
                SET_MODE <= 1'b1;
                D_H <= fix(Q_H, 8'h23);
                D_M <= fix(Q_M, 8'h59);
                D_S <= fix(Q_S, 8'h59);
                pend <= step;
                tmo <= '0;
            end
        end else begin
            D_H <= adj(D_H, ev[0], ev[1], 8'h23);
            D_M <= adj(D_M, ev[2], ev[3], 8'h59);
            D_S <= adj(D_S, ev[4], ev[5], 8'h59);
            pend <= '0;
            if (|ev) tmo <= '0;
            else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                state <= IDLE;
                PE <= 1'b0;
                SET_MODE <= 1'b0;
                tmo <= '0;
            end else tmo <= tmo + 1'b1;
        end
    end
endmodule

// File: tb/tb_timing_setter.sv
// tb_timing_setter: randomized and directed bench comparing timing_setter against a behavioural model.
module tb_timing_setter;
    localparam int DEB = 4, RD = 20, RP = 8, TO = 50;
    logic CP = 1'b0, CR = 1'b1;
    logic [5:0] btn = '0;
    logic [7:0] Q_H = 8'h12, Q_M = 8'h34, Q_S = 8'h56;
    logic [7:0] D_H, D_M, D_S;
    logic PE, SET_MODE;
    int checks = 0, failures = 0;
    bit cmp_en = 0;

    timing_setter #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .TIMEOUT_CYCLES(TO)) dut (
        .CP(CP), .CR(CR),
        .H_UP(btn[0]), .H_DOWN(btn[1]), .M_UP(btn[2]), .M_DOWN(btn[3]), .S_UP(btn[4]), .S_DOWN(btn[5]),
        .Q_H(Q_H), .Q_M(Q_M), .Q_S(Q_S),
        .D_H(D_H), .D_M(D_M), .D_S(D_S), .PE(PE), .SET_MODE(SET_MODE)
    );

    always #5 CP = ~CP;

    function automatic int bcd2i(input logic [7:0] v, input int mx);
        int t = int'(v[7:4]);
        int u = int'(v[3:0]);
        return (u <= 9 && t * 10 + u <= mx) ? t * 10 + u : 0;
    endfunction
    function automatic logic [7:0] i2bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction
    function automatic int stepf(input int v, input bit up, input bit dn, input int n);
        if (up == dn) return v;
        return up ? (v + 1) % n : (v + n - 1) % n;
    endfunction

    // model: decimal field values, hold time since debounced press, quiet time since last event
    int mh, mm, ms, quiet;
    bit mset;
    bit [5:0] sa, sb, mdeb, marm, mpend, st, ev;
    int run [6];
    int hold [6];

    initial forever begin
        @(posedge CP);
        if (CR) begin
            mh = 0; mm = 0; ms = 0; quiet = 0; mset = 0;
            sa = '1; sb = '1; mdeb = '0; marm = '0; mpend = '0;
            for (int i = 0; i < 6; i++) begin run[i] = 0; hold[i] = 0; end
        end else begin
            for (int i = 0; i < 6; i++)
                st[i] = marm[i] && mdeb[i] && (hold[i] == 0 || (hold[i] >= RD && (hold[i] - RD) % RP == 0));
            if (!mset) begin
                if (|st) begin
                    mset = 1;
                    mh = bcd2i(Q_H, 23); mm = bcd2i(Q_M, 59); ms = bcd2i(Q_S, 59);
                    mpend = st; quiet = 0;
                end
            end else begin
                ev = st | mpend;
                mpend = '0;
                mh = stepf(mh, ev[0], ev[1], 24);
                mm = stepf(mm, ev[2], ev[3], 60);
                ms = stepf(ms, ev[4], ev[5], 60);
                if (|ev) quiet = 0;
                else begin
                    quiet++;
                    if (quiet == TO) begin mset = 0; quiet = 0; end
                end
            end
            for (int i = 0; i < 6; i++) begin
                if (!mdeb[i] && !sb[i]) marm[i] = 1;
                hold[i] = mdeb[i] ? hold[i] + 1 : 0;
                if (sb[i] != mdeb[i]) begin
                    run[i]++;
                    if (run[i] == DEB) begin mdeb[i] = sb[i]; run[i] = 0; end
                end else run[i] = 0;
            end
            sb = sa;
            sa = btn;
        end
    end

    initial forever begin
        @(negedge CP);
        if (cmp_en) begin
            checks++;
            if ({PE, SET_MODE, D_H, D_M, D_S} !== {mset, mset, i2bcd(mh), i2bcd(mm), i2bcd(ms)}) begin
                failures++;
                $display("FAIL model t=%0t PE/SET=%b%b D=%h:%h:%h expected PE/SET=%b%b D=%h:%h:%h",
                         $time, PE, SET_MODE, D_H, D_M, D_S, mset, mset, i2bcd(mh), i2bcd(mm), i2bcd(ms));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CP);
    endtask
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask
    task automatic press(input logic [5:0] mk, input int n);
        btn = mk; tick(1); btn = '0; tick(1); btn = mk; tick(1); btn = '0; tick(1);
        btn = mk; tick(n); btn = '0; tick(12);
    endtask

    int seg, r, idx;
    logic [5:0] mask;

    initial begin
        tick(2);
        cmp_en = 1;
        CR = 0;
        chk("reset_pe", {7'd0, PE}, 8'h00);
        chk("reset_set", {7'd0, SET_MODE}, 8'h00);
        chk("reset_dh", D_H, 8'h00);
        chk("reset_dm", D_M, 8'h00);
        chk("reset_ds", D_S, 8'h00);
        tick(4);
        press(6'b000100, 10);
        chk("cap_pe", {7'd0, PE}, 8'h01);
        chk("cap_dh", D_H, 8'h12);
        chk("cap_dm", D_M, 8'h35);
        chk("cap_ds", D_S, 8'h56);
        tick(60);
        chk("timeout_pe", {7'd0, PE}, 8'h00);
        chk("hold_dm", D_M, 8'h35);
        Q_H = 8'h23; Q_M = 8'h09; Q_S = 8'h00;
        press(6'b000001, 8);
        chk("h_wrap_up", D_H, 8'h00);
        chk("m_capture", D_M, 8'h09);
        press(6'b000010, 8);
        chk("h_wrap_dn", D_H, 8'h23);
        press(6'b100000, 8);
        chk("s_wrap_dn", D_S, 8'h59);
        press(6'b000100, 8);
        chk("m_units_carry", D_M, 8'h10);
        press(6'b010000, 50);
        chk("s_repeat", D_S, 8'h04);
        press(6'b001100, 8);
        chk("m_updown", D_M, 8'h10);
        tick(60);
        Q_H = 8'h05; Q_M = 8'h10; Q_S = 8'h30;
        press(6'b100001, 8);
        chk("dual_h", D_H, 8'h06);
        chk("dual_s", D_S, 8'h29);
        tick(60);
        Q_H = 8'hA5; Q_M = 8'h34; Q_S = 8'h56;
        press(6'b000001, 8);
        chk("bad_h", D_H, 8'h01);
        chk("bad_h_m", D_M, 8'h34);
        btn[0] = 1; tick(10);
        CR = 1; tick(1); CR = 0;
        chk("cr_pe", {7'd0, PE}, 8'h00);
        chk("cr_dh", D_H, 8'h00);
        tick(40);
        chk("held_no_reentry", {7'd0, PE}, 8'h00);
        btn[0] = 0; tick(12);
        chk("release_idle", {7'd0, PE}, 8'h00);
        press(6'b000001, 8);
        chk("reentry_pe", {7'd0, PE}, 8'h01);
        chk("reentry_dh", D_H, 8'h01);
        seg = 0;
        mask = '0;
        for (int c = 0; c < 4000; c++) begin
            if (seg == 0) begin
                r = $urandom_range(0, 9);
                idx = $urandom_range(0, 5);
                mask = r < 3 ? 6'd0 : r < 8 ? 6'd1 << idx : 6'($urandom_range(0, 63));
                seg = $urandom_range(1, 70);
                if ($urandom_range(0, 3) == 0) begin
                    Q_H = $urandom_range(0, 1) ? 8'($urandom_range(0, 255)) : i2bcd($urandom_range(0, 23));
                    Q_M = $urandom_range(0, 1) ? 8'($urandom_range(0, 255)) : i2bcd($urandom_range(0, 59));
                    Q_S = $urandom_range(0, 1) ? 8'($urandom_range(0, 255)) : i2bcd($urandom_range(0, 59));
                end
            end
            btn = mask;
            if ($urandom_range(0, 9) == 0) begin
                idx = $urandom_range(0, 5);
                btn[idx] = ~btn[idx];
            end
            CR = ($urandom_range(0, 499) == 0);
            seg--;
            tick(1);
        end
        CR = 0;
        btn = '0;
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
